// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared constants for the program loader and the control unit:
//   - 4-bit opcode encoding of the BF instruction set (halt = 0)
//   - characters that terminate a program load
//   - loader FSM state type
package program_loader_pkg;

    localparam logic [3:0] OP_HALT  = 4'd0;
    localparam logic [3:0] OP_RIGHT = 4'd1;  // '>'
    localparam logic [3:0] OP_LEFT  = 4'd2;  // '<'
    localparam logic [3:0] OP_INC   = 4'd3;  // '+'
    localparam logic [3:0] OP_DEC   = 4'd4;  // '-'
    localparam logic [3:0] OP_OUT   = 4'd5;  // '.'
    localparam logic [3:0] OP_IN    = 4'd6;  // ','
    localparam logic [3:0] OP_JZ    = 4'd7;  // '['
    localparam logic [3:0] OP_JNZ   = 4'd8;  // ']'

    localparam logic [7:0] TERM_BANG = 8'h21;  // '!'
    localparam logic [7:0] TERM_NUL  = 8'h00;

    localparam logic [7:0] DEPTH_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_TERM,
        ST_DONE,
        ST_ERROR
    } load_state_e;

endpackage

// File: rtl/program_loader_char_decode.sv
// char_decode
// Combinational ASCII-to-opcode decoder.
// Ports:
//   char_code  in   8  ASCII character
//   isBF       out  1  character is one of the eight BF instructions
//   isTerm     out  1  character terminates the program ('!' or NUL)
//   opcode     out  4  opcode for a BF character, halt otherwise
module char_decode
    import program_loader_pkg::*;
(
    input  logic [7:0] char_code,
    output logic       isBF,
    output logic       isTerm,
    output logic [3:0] opcode
);

    always_comb begin
        isBF   = 1'b1;
        opcode = OP_HALT;
        case (char_code)
            8'h3E:   opcode = OP_RIGHT;  // '>'
            8'h3C:   opcode = OP_LEFT;   // '<'
            8'h2B:   opcode = OP_INC;    // '+'
            8'h2D:   opcode = OP_DEC;    // '-'
            8'h2E:   opcode = OP_OUT;    // '.'
            8'h2C:   opcode = OP_IN;     // ','
            8'h5B:   opcode = OP_JZ;     // '['
            8'h5D:   opcode = OP_JNZ;    // ']'
            default: isBF   = 1'b0;
        endcase
        isTerm = (char_code == TERM_BANG) || (char_code == TERM_NUL);
    end

endmodule

// File: rtl/program_loader.sv
// program_loader
// Streams ASCII BF source into program memory as 4-bit opcodes, one write
// per accepted instruction, terminated by a halt write. Bracket nesting is
// tracked while loading so an unbalanced program is rejected, and the
// pointer is bounded so the halt always fits at or below PROG_MAX.
// Ports:
//   clock        in   1       rising-edge clock
//   reset        in   1       asynchronous active-low reset
//   start        in   1       pulse: begin a new load at address 0
//   charValid    in   1       charIn holds a character
//   charIn       in   8       ASCII character
//   charReady    out  1       character accepted this cycle (when valid)
//   PMaddress    out  ADDR_W  program memory write address
//   PMdata       out  4       opcode to write
//   PMwren       out  1       program memory write enable
//   PMinputDone  out  1       load finished successfully (level)
//   loadError    out  1       load aborted (level)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PROG_MAX = 16'hFFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              charValid,
    input  logic [7:0]        charIn,
    output logic              charReady,
    output logic [ADDR_W-1:0] PMaddress,
    output logic [3:0]        PMdata,
    output logic              PMwren,
    output logic              PMinputDone,
    output logic              loadError
);

    load_state_e       state;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        depth;

    logic              is_bf;
    logic              is_term;
    logic [3:0]        char_op;
    logic              xfer;
    logic              bad_char;

    char_decode u_decode (
        .char_code (charIn),
        .isBF      (is_bf),
        .isTerm    (is_term),
        .opcode    (char_op)
    );

    // charReady is only ever high in ACCEPT, so this is the handshake.
    assign xfer = charValid && charReady;

    // A BF character that cannot be written: the halt would no longer fit,
    // or the bracket counter would wrap in either direction.
    assign bad_char = (ptr == PROG_MAX)
                   || ((char_op == OP_JZ)  && (depth == DEPTH_MAX))
                   || ((char_op == OP_JNZ) && (depth == 8'd0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            depth       <= '0;
            charReady   <= 1'b0;
            PMaddress   <= '0;
            PMdata      <= OP_HALT;
            PMwren      <= 1'b0;
            PMinputDone <= 1'b0;
            loadError   <= 1'b0;
        end else if (start) begin
            // Restart from any state. A write already on the bus this
            // cycle (WRITE or halting TERM) completes; it just is not
            // repeated.
            state       <= ST_ACCEPT;
            ptr         <= '0;
            depth       <= '0;
            charReady   <= 1'b1;
            PMwren      <= 1'b0;
            PMinputDone <= 1'b0;
            loadError   <= 1'b0;
        end else begin
            unique case (state)
                ST_ACCEPT: begin
                    if (xfer && is_term) begin
                        // Decide the halt write now so PMwren is registered
                        // for the TERM cycle; an open bracket suppresses it.
                        state     <= ST_TERM;
                        charReady <= 1'b0;
                        PMwren    <= (depth == 8'd0);
                        PMaddress <= ptr;
                        PMdata    <= OP_HALT;
                    end else if (xfer && is_bf) begin
                        charReady <= 1'b0;
                        if (bad_char) begin
                            state     <= ST_ERROR;
                            loadError <= 1'b1;
                        end else begin
                            state     <= ST_WRITE;
                            PMwren    <= 1'b1;
                            PMaddress <= ptr;
                            PMdata    <= char_op;
                            if (char_op == OP_JZ) begin
                                depth <= depth + 8'd1;
                            end else if (char_op == OP_JNZ) begin
                                depth <= depth - 8'd1;
                            end
                        end
                    end
                    // Other accepted characters are dropped; stay here.
                end
                ST_WRITE: begin
                    state     <= ST_ACCEPT;
                    PMwren    <= 1'b0;
                    ptr       <= ptr + 1'b1;
                    charReady <= 1'b1;
                end
                ST_TERM: begin
                    PMwren <= 1'b0;
                    if (PMwren) begin
                        state       <= ST_DONE;
                        PMinputDone <= 1'b1;
                    end else begin
                        state     <= ST_ERROR;
                        loadError <= 1'b1;
                    end
                end
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    charReady <= 1'b0;
                    PMwren    <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    charReady <= 1'b0;
                    PMwren    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 16, program memory address width.
REQ-002 Parameter PROG_MAX, default 16'hFFFF, highest writable program address; the halt opcode occupies at most this address.
REQ-003 clock  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a new load from address 0.
REQ-006 charValid  input  1  charIn holds a character this cycle.
REQ-007 charIn  input  8  ASCII program character.
REQ-008 charReady  output  1  loader accepts charIn this cycle.
REQ-009 PMaddress  output  ADDR_W  program memory write address.
REQ-010 PMdata  output  4  opcode to write.
REQ-011 PMwren  output  1  program memory write enable, one cycle per write.
REQ-012 PMinputDone  output  1  level; program loaded with halt and brackets balanced.
REQ-013 loadError  output  1  level; load aborted (bracket mismatch or overflow).

Function
REQ-014 Opcode map, shared with control: halt=0, '>'=1, '<'=2, '+'=3, '-'=4, '.'=5, ','=6, '['=7, ']'=8; 9-15 unused.
REQ-015 Terminator characters: '!' (8'h21) or NUL (8'h00).
REQ-016 FSM states: IDLE, ACCEPT, WRITE, TERM, DONE, ERROR.
REQ-017 IDLE: charReady=0, PMwren=0; start -> ACCEPT, write pointer := 0, bracket depth := 0, PMinputDone := 0, loadError := 0.
REQ-018 ACCEPT: charReady=1; a transfer occurs when charValid & charReady are both high.
REQ-019 ACCEPT, transfer of a BF character -> WRITE; opcode and pointer registered.
REQ-020 ACCEPT, transfer of a non-BF, non-terminator character: character discarded, state stays ACCEPT, no write.
REQ-021 ACCEPT, transfer of a terminator -> TERM.
REQ-022 WRITE: exactly one cycle; PMwren=1, PMaddress=pointer, PMdata=opcode, charReady=0; then pointer += 1 and state -> ACCEPT.
REQ-023 Sustained throughput is one BF character per two cycles.
REQ-024 '[' increments depth (8-bit); ']' decrements depth.
REQ-025 ']' at depth 0 -> ERROR with no write.
REQ-026 '[' at depth 255 -> ERROR with no write.
REQ-027 A BF character accepted when pointer == PROG_MAX -> ERROR with no write, because the halt opcode must still fit.
REQ-028 TERM, depth != 0 -> ERROR with no write.
REQ-029 TERM, depth == 0: one cycle with PMwren=1, PMdata=0, PMaddress=pointer; then -> DONE.
REQ-030 DONE: PMinputDone=1, charReady=0.
REQ-031 ERROR: loadError=1, charReady=0.
REQ-032 In DONE or ERROR, start begins a new load exactly as from IDLE and clears both flags.
REQ-033 start in ACCEPT, WRITE or TERM restarts the load (pointer := 0, depth := 0); a WRITE in progress that same cycle still completes its write.
REQ-034 charValid outside ACCEPT is ignored; the loader never drops a character it has asserted charReady for.

Reset
REQ-035 On reset low, asynchronously: state=IDLE, pointer=0, depth=0, charReady=0, PMwren=0, PMaddress=0, PMdata=0, PMinputDone=0, loadError=0.
REQ-036 A load interrupted by reset is abandoned; no partial write occurs after reset asserts.

Structure
REQ-037 A shared package holds the opcode constants and terminator constants, for use by both program_loader and control.
REQ-038 One sub-module, char_decode, is combinational ASCII-to-opcode with outputs isBF, isTerm and opcode[3:0].

Verification
REQ-039 Load "+[->+<]!" -> 8 writes, addresses 0..7 with data 3,7,4,1,3,2,8,0; PMinputDone=1; loadError=0.
REQ-040 Load "a+ b\n.!" -> writes of 3@0, 5@1, 0@2 only; the non-BF characters produce no PMwren.
REQ-041 Load "]!" -> no PMwren; loadError=1; and "[[]!" -> writes 7@0, 7@1, 8@2, then loadError=1 with no halt write.
REQ-042 Set PROG_MAX=3 and load "++++!" -> writes 3@0..2, fourth '+' -> loadError=1.
REQ-043 Hold charValid=1 constantly -> charReady toggles 1,0,1,0; each character is written exactly once.
REQ-044 Assert reset during WRITE -> all outputs reach their reset values with no clock edge needed; then start plus "+!" -> 3@0, 0@1, PMinputDone=1.
